// File: rtl/cmem_regs.sv
// rtl/cmem_regs.sv - communication-memory register file with Amiga and Pi access ports
// Sixteen 4-bit registers; 12-15 are the event/enable pairs that drive the two interrupts.
module cmem_regs (
  input  logic       clk200,
  input  logic       reset_n,
  input  logic [3:0] cp_address,
  input  logic [3:0] cp_data_out,
  input  logic       cp_read_cmem,
  input  logic       cp_write_cmem,
  output logic [3:0] cp_in_cmem_out,
  input  logic       bank_wr,
  input  logic       bank_wr_data,
  output logic       cmem_bank,
  input  logic [3:0] pi_address,
  input  logic [3:0] pi_data_in,
  input  logic       pi_rd,
  input  logic       pi_wr,
  output logic [3:0] pi_data_out,
  output logic       int_amiga,
  output logic       int_pi
);

  localparam logic [3:0] A_EVENTS = 4'd12;
  localparam logic [3:0] A_ENABLE = 4'd13;
  localparam logic [3:0] R_EVENTS = 4'd14;
  localparam logic [3:0] R_ENABLE = 4'd15;

  logic [3:0] regs      [16];
  logic [3:0] regs_next [16];
  logic       cp_wr_a_ev;
  logic       pi_wr_a_ev;
  logic       cp_wr_r_ev;
  logic       pi_wr_r_ev;
  logic [3:0] a_set;
  logic [3:0] a_clr;
  logic [3:0] r_set;
  logic [3:0] r_clr;

  assign cp_wr_a_ev = cp_write_cmem && (cp_address == A_EVENTS);
  assign pi_wr_a_ev = pi_wr && (pi_address == A_EVENTS);
  assign cp_wr_r_ev = cp_write_cmem && (cp_address == R_EVENTS);
  assign pi_wr_r_ev = pi_wr && (pi_address == R_EVENTS);

  // Each event register has one setting side and one clearing side.
  assign a_set = pi_wr_a_ev ? pi_data_in  : 4'h0;
  assign a_clr = cp_wr_a_ev ? cp_data_out : 4'h0;
  assign r_set = cp_wr_r_ev ? cp_data_out : 4'h0;
  assign r_clr = pi_wr_r_ev ? pi_data_in  : 4'h0;

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      regs_next[i] = regs[i];
    end
    // Amiga write is applied last so it wins a same-index collision.
    for (int i = 0; i < 12; i++) begin
      if (pi_wr && (pi_address == 4'(i))) begin
        regs_next[i] = pi_data_in;
      end
      if (cp_write_cmem && (cp_address == 4'(i))) begin
        regs_next[i] = cp_data_out;
      end
    end
    regs_next[12] = (regs[12] & ~a_clr) | a_set;
    if (cp_write_cmem && (cp_address == A_ENABLE)) begin
      regs_next[13] = cp_data_out;
    end
    regs_next[14] = (regs[14] & ~r_clr) | r_set;
    if (pi_wr && (pi_address == R_ENABLE)) begin
      regs_next[15] = pi_data_in;
    end
  end

  always_ff @(posedge clk200) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= 4'h0;
      end
      cp_in_cmem_out <= 4'h0;
      pi_data_out    <= 4'h0;
      cmem_bank      <= 1'b0;
      int_amiga      <= 1'b0;
      int_pi         <= 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= regs_next[i];
      end
      if (cp_read_cmem) begin
        cp_in_cmem_out <= regs[cp_address];
      end
      if (pi_rd) begin
        pi_data_out <= regs[pi_address];
      end
      if (bank_wr) begin
        cmem_bank <= bank_wr_data;
      end
      int_amiga <= |(regs[12] & regs[13]);
      int_pi    <= |(regs[14] & regs[15]);
    end
  end

endmodule

// File: tb/tb_cmem_regs.sv
// tb/tb_cmem_regs.sv - directed and randomized checks of cmem_regs against a reference model
module tb_cmem_regs;

  logic       clk200 = 1'b0;
  logic       reset_n;
  logic [3:0] cp_address;
  logic [3:0] cp_data_out;
  logic       cp_read_cmem;
  logic       cp_write_cmem;
  logic [3:0] cp_in_cmem_out;
  logic       bank_wr;
  logic       bank_wr_data;
  logic       cmem_bank;
  logic [3:0] pi_address;
  logic [3:0] pi_data_in;
  logic       pi_rd;
  logic       pi_wr;
  logic [3:0] pi_data_out;
  logic       int_amiga;
  logic       int_pi;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] m_reg [16];
  logic [3:0] m_cp;
  logic [3:0] m_pi;
  logic       m_bank;
  logic       m_ia;
  logic       m_ip;

  cmem_regs dut (
    .clk200         (clk200),
    .reset_n        (reset_n),
    .cp_address     (cp_address),
    .cp_data_out    (cp_data_out),
    .cp_read_cmem   (cp_read_cmem),
    .cp_write_cmem  (cp_write_cmem),
    .cp_in_cmem_out (cp_in_cmem_out),
    .bank_wr        (bank_wr),
    .bank_wr_data   (bank_wr_data),
    .cmem_bank      (cmem_bank),
    .pi_address     (pi_address),
    .pi_data_in     (pi_data_in),
    .pi_rd          (pi_rd),
    .pi_wr          (pi_wr),
    .pi_data_out    (pi_data_out),
    .int_amiga      (int_amiga),
    .int_pi         (int_pi)
  );

  always #5 clk200 = ~clk200;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: what one clock edge does to the register file, from the access rules.
  task automatic model_edge();
    logic [3:0] old [16];
    logic [3:0] set12, clr12, set14, clr14;
    old = m_reg;
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) m_reg[i] = 4'h0;
      m_cp = 4'h0; m_pi = 4'h0; m_bank = 1'b0; m_ia = 1'b0; m_ip = 1'b0;
      return;
    end
    if (cp_read_cmem) m_cp = old[cp_address];
    if (pi_rd) m_pi = old[pi_address];
    if (bank_wr) m_bank = bank_wr_data;
    m_ia = (old[12] & old[13]) != 4'h0;
    m_ip = (old[14] & old[15]) != 4'h0;
    set12 = 4'h0; clr12 = 4'h0; set14 = 4'h0; clr14 = 4'h0;
    if (pi_wr) begin
      if (pi_address < 12) m_reg[pi_address] = pi_data_in;
      else if (pi_address == 12) set12 = pi_data_in;
      else if (pi_address == 14) clr14 = pi_data_in;
      else if (pi_address == 15) m_reg[15] = pi_data_in;
    end
    if (cp_write_cmem) begin
      if (cp_address < 12) m_reg[cp_address] = cp_data_out;
      else if (cp_address == 12) clr12 = cp_data_out;
      else if (cp_address == 13) m_reg[13] = cp_data_out;
      else if (cp_address == 14) set14 = cp_data_out;
    end
    m_reg[12] = (old[12] & ~clr12) | set12;
    m_reg[14] = (old[14] & ~clr14) | set14;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk200);
    #1;
    cp_read_cmem = 0; cp_write_cmem = 0; pi_rd = 0; pi_wr = 0; bank_wr = 0;
  endtask

  task automatic cp_wr(input logic [3:0] a, input logic [3:0] d);
    cp_address = a; cp_data_out = d; cp_write_cmem = 1; tick();
  endtask

  task automatic pi_wrt(input logic [3:0] a, input logic [3:0] d);
    pi_address = a; pi_data_in = d; pi_wr = 1; tick();
  endtask

  task automatic cp_rd_chk(input string tag, input logic [3:0] a, input logic [3:0] exp);
    cp_address = a; cp_read_cmem = 1; tick();
    chk(tag, cp_in_cmem_out, exp);
  endtask

  task automatic pi_rd_chk(input string tag, input logic [3:0] a, input logic [3:0] exp);
    pi_address = a; pi_rd = 1; tick();
    chk(tag, pi_data_out, exp);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_reg[i] = 4'hx;
    reset_n = 0; cp_address = 0; cp_data_out = 0; cp_read_cmem = 0; cp_write_cmem = 0;
    bank_wr = 0; bank_wr_data = 0; pi_address = 0; pi_data_in = 0; pi_rd = 0; pi_wr = 0;
    tick(); tick();
    reset_n = 1;
    chk("reset_bank", {3'b0, cmem_bank}, 4'h0);
    chk("reset_int_amiga", {3'b0, int_amiga}, 4'h0);
    chk("reset_int_pi", {3'b0, int_pi}, 4'h0);
    chk("reset_pi_out", pi_data_out, 4'h0);
    for (int i = 0; i < 16; i++) cp_rd_chk($sformatf("reset_reg%0d", i), 4'(i), 4'h0);

    pi_wrt(13, 4'hF);
    cp_wr(15, 4'hF);
    cp_rd_chk("ro_a_enable", 13, 4'h0);
    pi_rd_chk("ro_r_enable", 15, 4'h0);

    cp_wr(3, 4'hA);
    pi_rd_chk("pi_rd_reg3", 3, 4'hA);
    pi_wrt(3, 4'h5);
    cp_rd_chk("cp_rd_reg3", 3, 4'h5);

    cp_wr(13, 4'h1);
    pi_wrt(12, 4'h3);
    chk("int_amiga_not_yet", {3'b0, int_amiga}, 4'h0);
    tick();
    chk("int_amiga_rise", {3'b0, int_amiga}, 4'h1);
    cp_wr(12, 4'h1);
    tick();
    chk("int_amiga_fall", {3'b0, int_amiga}, 4'h0);
    pi_rd_chk("a_events_w1c", 12, 4'h2);
    cp_wr(13, 4'h2);
    tick();
    chk("int_amiga_reenable", {3'b0, int_amiga}, 4'h1);

    cp_address = 5; cp_data_out = 4'h9; cp_write_cmem = 1;
    pi_address = 5; pi_data_in = 4'h6; pi_wr = 1;
    tick();
    cp_rd_chk("conflict_plain", 5, 4'h9);
    cp_wr(14, 4'h1);
    cp_address = 14; cp_data_out = 4'h1; cp_write_cmem = 1;
    pi_address = 14; pi_data_in = 4'h1; pi_wr = 1;
    tick();
    pi_rd_chk("conflict_event", 14, 4'h1);
    chk("int_pi_disabled", {3'b0, int_pi}, 4'h0);

    cp_address = 7; cp_data_out = 4'h4; cp_write_cmem = 1;
    pi_address = 7; pi_rd = 1;
    tick();
    chk("read_pre_edge", pi_data_out, 4'h0);
    pi_rd_chk("read_post_edge", 7, 4'h4);

    bank_wr = 1; bank_wr_data = 1; tick();
    chk("bank_load", {3'b0, cmem_bank}, 4'h1);
    tick();
    chk("bank_hold", {3'b0, cmem_bank}, 4'h1);

    reset_n = 0; pi_address = 3; pi_data_in = 4'hF; pi_wr = 1;
    tick();
    reset_n = 1;
    chk("midreset_bank", {3'b0, cmem_bank}, 4'h0);
    chk("midreset_int_amiga", {3'b0, int_amiga}, 4'h0);
    chk("midreset_pi_out", pi_data_out, 4'h0);
    cp_rd_chk("midreset_reg3", 3, 4'h0);
    cp_rd_chk("midreset_reg13", 13, 4'h0);

    for (int n = 0; n < 500; n++) begin
      reset_n       = ($urandom_range(0, 63) != 0);
      cp_address    = 4'($urandom);
      cp_data_out   = 4'($urandom);
      cp_read_cmem  = 1'($urandom);
      cp_write_cmem = 1'($urandom);
      pi_address    = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(12, 15)) : 4'($urandom);
      pi_data_in    = 4'($urandom);
      pi_rd         = 1'($urandom);
      pi_wr         = 1'($urandom);
      bank_wr       = ($urandom_range(0, 7) == 0);
      bank_wr_data  = 1'($urandom);
      tick();
      chk("rnd_cp_out", cp_in_cmem_out, m_cp);
      chk("rnd_pi_out", pi_data_out, m_pi);
      chk("rnd_bank", {3'b0, cmem_bank}, {3'b0, m_bank});
      chk("rnd_int_amiga", {3'b0, int_amiga}, {3'b0, m_ia});
      chk("rnd_int_pi", {3'b0, int_pi}, {3'b0, m_ip});
    end
    reset_n = 1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cmem_regs.md
Name: cmem_regs

Overview:
- Communication-memory register file sitting directly downstream of the clock-port front end.
- Consumes the one-cycle cmem read/write strobes, latched address and write nibble, and returns the read nibble (cp_in_cmem_out).
- Provides a second access port for the Pi side, plus event/enable registers that generate one interrupt toward the Amiga and one toward the Pi.
- Owns the cmem_bank select bit consumed by the clock port.

Parameters:
- None.

Ports:
- clk200  input  1  system clock
- reset_n  input  1  synchronous active-low reset
- cp_address  input  4  register index from clock port
- cp_data_out  input  4  write nibble from clock port
- cp_read_cmem  input  1  one-cycle Amiga read strobe
- cp_write_cmem  input  1  one-cycle Amiga write strobe
- cp_in_cmem_out  output  4  Amiga read data
- bank_wr  input  1  one-cycle strobe from RTC emulation, loads bank bit
- bank_wr_data  input  1  new cmem_bank value
- cmem_bank  output  1  bank select to clock port
- pi_address  input  4  Pi register index
- pi_data_in  input  4  Pi write nibble
- pi_rd  input  1  one-cycle Pi read strobe
- pi_wr  input  1  one-cycle Pi write strobe
- pi_data_out  output  4  Pi read data
- int_amiga  output  1  Amiga interrupt request
- int_pi  output  1  Pi interrupt request

Behaviour:
- Clock and reset:
  - All state updates on posedge clk200.
  - reset_n low at an edge clears regs 0–15, cp_in_cmem_out, pi_data_out, cmem_bank, int_amiga and int_pi to 0.
  - Reset overrides any strobe in the same cycle.
- Register map (16 x 4 bit):
  - 0–11: plain shared storage, read/write from both ports.
  - 12 A_EVENTS:
    - Pi write ORs data in (set bits).
    - Amiga write clears the bits written as 1 (W1C).
  - 13 A_ENABLE: Amiga read/write; Pi read-only, Pi writes ignored.
  - 14 R_EVENTS:
    - Amiga write ORs data in.
    - Pi write is W1C.
  - 15 R_ENABLE: Pi read/write; Amiga read-only, Amiga writes ignored.
- Reads:
  - cp_read_cmem: cp_in_cmem_out <= reg[cp_address] at that edge, i.e. valid 1 cycle after the strobe. Held until the next cp_read_cmem.
  - pi_rd: pi_data_out <= reg[pi_address], same timing and hold.
  - A read sees the pre-edge value, even if a write to the same register lands on the same edge.
- Simultaneous writes to the same index:
  - Plain reg 0–11: Amiga write wins; Pi write is dropped.
  - Event reg: per bit, set beats clear. Next value = (old & ~clr) | set.
  - Writes to different indices both complete.
- cmem_bank: bank_wr loads bank_wr_data. Holds otherwise.
- Interrupts (registered, 1 cycle after the event/enable change):
  - int_amiga <= |(A_EVENTS & A_ENABLE)
  - int_pi <= |(R_EVENTS & R_ENABLE)
  - Both are level outputs and drop 1 cycle after the causing bits are cleared or disabled.
- Strobes:
  - Strobes are assumed single-cycle.
  - A strobe held high repeats its action each cycle. For W1C/OR this is idempotent.
  - Reads have no side effects.
- No internal state machine beyond the registers. Logic is a pure registered update per cycle.

Test Plan:
- Reset, then Amiga read of every index -> cp_in_cmem_out = 0x0; cmem_bank=0; int_amiga=int_pi=0.
- Amiga write reg 3 = 0xA; Pi read reg 3 -> pi_data_out = 0xA one cycle after pi_rd. Pi write reg 3 = 0x5; Amiga read -> 0x5.
- Interrupt path to Amiga:
  - Amiga writes A_ENABLE = 0x1; Pi writes A_EVENTS = 0x3 -> int_amiga rises 1 cycle after the write edge.
  - Amiga writes A_EVENTS = 0x1 -> A_EVENTS = 0x2, int_amiga falls.
  - Amiga writes A_ENABLE = 0x2 -> int_amiga = 1 again.
- Same-cycle conflicts:
  - Amiga write reg 5 = 0x9 and Pi write reg 5 = 0x6 -> reg 5 = 0x9.
  - With R_EVENTS = 0x1, same-cycle Amiga write R_EVENTS = 0x1 and Pi W1C 0x1 -> R_EVENTS = 0x1.
- Read-only enforcement: Pi writes A_ENABLE = 0xF and Amiga writes R_ENABLE = 0xF -> both read back 0x0.
- bank_wr = 1 with data 1 -> cmem_bank = 1 next cycle. reset_n low mid-operation with pi_wr asserted -> all regs 0, write discarded.
